// File: rtl/primogen_pkg.sv
// primogen_pkg: shared FSM state encoding and small-prime lookup constants for primogen_wide.
package primogen_pkg;

   typedef enum logic [2:0] {IDLE, START, TEST, DIV, STEP} state_t;

   localparam int TABLE_LIMIT = 64;
   // Bit n set when n is prime, for 0 <= n < 64.
   localparam logic [63:0] PRIME_MASK_64 = 64'h28208A20_A08A28AC;

   function automatic logic table_prime(input logic [5:0] n);
      return PRIME_MASK_64[n];
   endfunction

endpackage

// File: rtl/primogen_wide_if.sv
// primogen_wide_if: go/ready request bus between a host and the prime generator.
interface primogen_wide_if #(parameter int WIDTH = 16);
   logic             go;
   logic             load;
   logic [WIDTH-1:0] seed;
   logic             ready;
   logic             error;
   logic [WIDTH-1:0] res;

   modport master (output go, load, seed, input ready, error, res);
   modport slave  (input go, load, seed, output ready, error, res);
endinterface

// File: rtl/primogen_divmod.sv
// primogen_divmod: restoring remainder unit; one setup cycle on start, W iterations, then a 1-cycle done pulse.
module primogen_divmod #(parameter int W = 17) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] num,
   input  logic [W-1:0] den,
   output logic         done,
   output logic [W-1:0] rem
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  num_q, den_q, rem_q;
   logic [CW-1:0] cnt_q;
   logic          done_q;
   logic [W:0]    shift_d;
   logic          ge_d;

   assign shift_d = {rem_q, num_q[W-1]};
   assign ge_d    = shift_d >= {1'b0, den_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         num_q  <= '0;
         den_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= cnt_q == CW'(1);
         if (start) begin
            num_q <= num;
            den_q <= den;
            rem_q <= '0;
            cnt_q <= CW'(W);
         end else if (cnt_q != '0) begin
            rem_q <= ge_d ? W'(shift_d - {1'b0, den_q}) : shift_d[W-1:0];
            num_q <= num_q << 1;
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   assign done = done_q;
   assign rem  = rem_q;
endmodule

// File: rtl/primogen_wide.sv
// primogen_wide: WIDTH-bit prime sequence generator with seeded restart and sticky overflow error.
// Define PRIMOGEN_TABLE_EN to decide candidates below 64 from a constant mask instead of dividing.
module primogen_wide
   import primogen_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic            clk,
   input logic            rst,
   primogen_wide_if.slave bus
);
   typedef logic [WIDTH-1:0]   rw_t;
   typedef logic [WIDTH:0]     cw_t;
   typedef logic [2*WIDTH-1:0] sq_t;

   state_t state_q;
   rw_t    res_q;
   logic   err_q, ready_q, ld_q, start_q;
   cw_t    cand_q, d_q;
   sq_t    dsq_q;
   cw_t    cand_d, d_d;
   sq_t    dsq_d;
   logic   div_done;
   cw_t    div_rem;

   assign cand_d = cand_q + cw_t'(2);
   assign d_d    = d_q + cw_t'(2);
   // (d+2)^2 = d^2 + 4d + 4 keeps the bound test multiplier-free
   assign dsq_d  = dsq_q + sq_t'({d_q, 2'b00}) + sq_t'(4);

   primogen_divmod #(.W(WIDTH + 1)) u_div (
      .clk  (clk),
      .rst  (rst),
      .start(start_q),
      .num  (cand_q),
      .den  (d_q),
      .done (div_done),
      .rem  (div_rem)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= rw_t'(1);
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         ld_q    <= 1'b0;
         start_q <= 1'b0;
         cand_q  <= '0;
         d_q     <= '0;
         dsq_q   <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            IDLE:
               if (bus.go && (bus.load || !err_q)) begin
                  ready_q <= 1'b0;
                  ld_q    <= bus.load;
                  cand_q  <= {1'b0, bus.seed};
                  if (bus.load) err_q <= 1'b0;
                  state_q <= START;
               end
            START: begin
               d_q     <= cw_t'(3);
               dsq_q   <= sq_t'(9);
               state_q <= TEST;
               if (ld_q) begin
                  if (cand_q <= cw_t'(1)) begin
                     res_q   <= rw_t'(1);
                     ready_q <= 1'b1;
                     state_q <= IDLE;
                  end else if (cand_q != cw_t'(2) && !cand_q[0]) cand_q <= cand_q + cw_t'(1);
               end else
                  cand_q <= res_q == rw_t'(1) ? cw_t'(2) : res_q == rw_t'(2) ? cw_t'(3) : {1'b0, res_q} + cw_t'(2);
            end
            TEST:
               if (cand_q[WIDTH]) begin
                  err_q   <= 1'b1;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end else if (cand_q == cw_t'(2) || cand_q == cw_t'(3)) begin
                  res_q   <= cand_q[WIDTH-1:0];
                  err_q   <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
`ifdef PRIMOGEN_TABLE_EN
               end else if (33'(cand_q) < 33'(TABLE_LIMIT)) begin
                  if (table_prime(cand_q[5:0])) begin
                     res_q   <= cand_q[WIDTH-1:0];
                     err_q   <= 1'b0;
                     ready_q <= 1'b1;
                     state_q <= IDLE;
                  end else state_q <= STEP;
`endif
               end else if (dsq_q > sq_t'(cand_q)) begin
                  res_q   <= cand_q[WIDTH-1:0];
                  err_q   <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  start_q <= 1'b1;
                  state_q <= DIV;
               end
            DIV:
               if (div_done) begin
                  if (div_rem == '0) state_q <= STEP;
                  else begin
                     d_q     <= d_d;
                     dsq_q   <= dsq_d;
                     state_q <= TEST;
                  end
               end
            STEP: begin
               cand_q  <= cand_d;
               d_q     <= cw_t'(3);
               dsq_q   <= sq_t'(9);
               state_q <= TEST;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.res   = res_q;
   assign bus.ready = ready_q;
   assign bus.error = err_q;
endmodule

// File: tb/tb_primogen_wide.sv
// tb_primogen_wide: random and directed checks of a 16-bit and an 8-bit primogen_wide against a sieve model.
module tb_primogen_wide;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   primogen_wide_if #(.WIDTH(16)) if16 ();
   primogen_wide_if #(.WIDTH(8))  if8 ();

   primogen_wide #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
   primogen_wide #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));

   int checks = 0;
   int errors = 0;
   bit comp [0:65535];
   int m_res [2];
   bit m_err [2];

   function automatic int next_prime(input int x, input int w);
      for (int n = x; n < (1 << w); n++) if (n >= 2 && !comp[n]) return n;
      return -1;
   endfunction

   function automatic logic [15:0] rd_res(input int k);
      return k != 0 ? {8'b0, if8.res} : if16.res;
   endfunction

   function automatic logic rd_rdy(input int k);
      return k != 0 ? if8.ready : if16.ready;
   endfunction

   function automatic logic rd_err(input int k);
      return k != 0 ? if8.error : if16.error;
   endfunction

   task automatic set_in(input int k, input bit g, input bit l, input int s);
      if (k != 0) begin
         if8.go = g; if8.load = l; if8.seed = 8'(s);
      end else begin
         if16.go = g; if16.load = l; if16.seed = 16'(s);
      end
   endtask

   task automatic model_reset();
      m_res[0] = 1; m_res[1] = 1;
      m_err[0] = 0; m_err[1] = 0;
   endtask

   task automatic model_op(input int k, input bit l, input int s, output bit acc);
      int p;
      acc = l || !m_err[k];
      if (!acc) return;
      if (l && s <= 1) begin
         m_res[k] = 1; m_err[k] = 0;
         return;
      end
      p = next_prime(l ? s : m_res[k] + 1, k != 0 ? 8 : 16);
      if (p < 0) m_err[k] = 1;
      else begin
         m_res[k] = p; m_err[k] = 0;
      end
   endtask

   // Pulses go for one cycle; ok reports ready dropping (accepted) or staying high (ignored) with res held.
   task automatic op(input int k, input bit l, input int s, input bit acc, output bit to, output bit ok);
      logic [15:0] h;
      int c;
      to = 0; ok = 1;
      @(negedge clk); set_in(k, 1, l, s);
      @(negedge clk); set_in(k, 0, 0, 0);
      h = rd_res(k);
      if (acc) begin
         ok = rd_rdy(k) === 1'b0;
         c = 0;
         while (rd_rdy(k) !== 1'b1 && c < 20000) begin
            if (rd_res(k) !== h) ok = 0;
            @(negedge clk); c++;
         end
         to = c >= 20000;
      end else
         repeat (4) begin
            if (rd_rdy(k) !== 1'b1 || rd_res(k) !== h) ok = 0;
            @(negedge clk);
         end
   endtask

   task automatic test_reset();
      set_in(0, 0, 0, 0); set_in(1, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         checks++; if (rd_res(k) !== 16'd1) begin errors++; $display("FAIL reset_res dut%0d got %0d want 1", k, rd_res(k)); end
         checks++; if (rd_rdy(k) !== 1'b1) begin errors++; $display("FAIL reset_ready dut%0d got %b want 1", k, rd_rdy(k)); end
         checks++; if (rd_err(k) !== 1'b0) begin errors++; $display("FAIL reset_error dut%0d got %b want 0", k, rd_err(k)); end
      end
   endtask

   task automatic test_sequence();
      int exp13 [13] = '{1, 2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37};
      bit acc, to, ok;
      for (int i = 1; i < 100; i++) begin
         model_op(0, 0, 0, acc);
         op(0, 0, 0, acc, to, ok);
         checks++; if (to || !ok) begin errors++; $display("FAIL seq_handshake #%0d timeout %0d ok %0d want timeout 0 ok 1", i, to, ok); end
         checks++; if (rd_res(0) !== 16'(m_res[0])) begin errors++; $display("FAIL seq_res #%0d got %0d want %0d", i, rd_res(0), m_res[0]); end
         checks++; if (rd_err(0) !== 1'b0) begin errors++; $display("FAIL seq_error #%0d got %b want 0", i, rd_err(0)); end
         if (i < 13) begin
            checks++; if (rd_res(0) !== 16'(exp13[i])) begin errors++; $display("FAIL seq_list #%0d got %0d want %0d", i, rd_res(0), exp13[i]); end
         end
      end
   endtask

   task automatic test_seeded();
      int seeds [6] = '{90, 97, 0, 2, 65530, 97};
      int er [6]    = '{97, 97, 1, 2, 2, 97};
      bit ee [6]    = '{0, 0, 0, 0, 1, 0};
      bit acc, to, ok, l;
      int s;
      for (int i = 0; i < 6; i++) begin
         model_op(0, 1, seeds[i], acc);
         op(0, 1, seeds[i], acc, to, ok);
         checks++; if (to || !ok) begin errors++; $display("FAIL seed_handshake seed %0d timeout %0d ok %0d", seeds[i], to, ok); end
         checks++; if (rd_res(0) !== 16'(er[i]) || rd_res(0) !== 16'(m_res[0])) begin errors++; $display("FAIL seed_res seed %0d got %0d want %0d", seeds[i], rd_res(0), er[i]); end
         checks++; if (rd_err(0) !== ee[i]) begin errors++; $display("FAIL seed_error seed %0d got %b want %b", seeds[i], rd_err(0), ee[i]); end
      end
      model_op(0, 0, 0, acc);
      op(0, 0, 0, acc, to, ok);
      checks++; if (to || rd_res(0) !== 16'd101) begin errors++; $display("FAIL after_97 got %0d want 101 timeout %0d", rd_res(0), to); end
      for (int i = 0; i < 12; i++) begin
         l = $urandom_range(0, 2) != 0;
         s = $urandom_range(0, 4000);
         model_op(0, l, s, acc);
         op(0, l, s, acc, to, ok);
         checks++; if (to || !ok) begin errors++; $display("FAIL rand_handshake load %0d seed %0d timeout %0d ok %0d", l, s, to, ok); end
         checks++; if (rd_res(0) !== 16'(m_res[0]) || rd_err(0) !== m_err[0]) begin errors++; $display("FAIL rand_res load %0d seed %0d got %0d/%b want %0d/%b", l, s, rd_res(0), rd_err(0), m_res[0], m_err[0]); end
      end
   endtask

   task automatic test_overflow();
      bit acc, to, ok, l;
      int s;
      model_op(1, 1, 250, acc);
      op(1, 1, 250, acc, to, ok);
      checks++; if (to || rd_res(1) !== 16'd251 || rd_err(1) !== 1'b0) begin errors++; $display("FAIL ovf_seed250 got %0d/%b want 251/0", rd_res(1), rd_err(1)); end
      model_op(1, 0, 0, acc);
      op(1, 0, 0, acc, to, ok);
      checks++; if (to || !ok || rd_err(1) !== 1'b1 || rd_rdy(1) !== 1'b1) begin errors++; $display("FAIL ovf_error got err %b ready %b want 1 1", rd_err(1), rd_rdy(1)); end
      checks++; if (rd_res(1) !== 16'd251) begin errors++; $display("FAIL ovf_hold got %0d want 251", rd_res(1)); end
      model_op(1, 0, 0, acc);
      op(1, 0, 0, acc, to, ok);
      checks++; if (acc || !ok || rd_err(1) !== 1'b1 || rd_res(1) !== 16'd251) begin errors++; $display("FAIL ovf_ignore got %0d/%b ok %0d want 251/1 ok 1", rd_res(1), rd_err(1), ok); end
      model_op(1, 1, 3, acc);
      op(1, 1, 3, acc, to, ok);
      checks++; if (to || rd_res(1) !== 16'd3 || rd_err(1) !== 1'b0) begin errors++; $display("FAIL ovf_recover got %0d/%b want 3/0", rd_res(1), rd_err(1)); end
      for (int i = 0; i < 10; i++) begin
         l = $urandom_range(0, 1) != 0;
         s = $urandom_range(180, 255);
         model_op(1, l, s, acc);
         op(1, l, s, acc, to, ok);
         checks++; if (to || !ok || rd_res(1) !== 16'(m_res[1]) || rd_err(1) !== m_err[1]) begin errors++; $display("FAIL ovf_rand load %0d seed %0d got %0d/%b want %0d/%b", l, s, rd_res(1), rd_err(1), m_res[1], m_err[1]); end
      end
   endtask

   task automatic test_busy();
      bit acc, to, ok;
      int c;
      model_op(0, 1, 97, acc);
      op(0, 1, 97, acc, to, ok);
      checks++; if (to || rd_res(0) !== 16'd97) begin errors++; $display("FAIL busy_setup got %0d want 97", rd_res(0)); end
      model_op(0, 0, 0, acc);
      @(negedge clk); set_in(0, 1, 0, 0);
      repeat (5) @(negedge clk);
      set_in(0, 0, 0, 0);
      c = 0;
      while (rd_rdy(0) !== 1'b1 && c < 20000) begin @(negedge clk); c++; end
      checks++; if (c >= 20000 || rd_res(0) !== 16'(m_res[0])) begin errors++; $display("FAIL busy_one got %0d want %0d", rd_res(0), m_res[0]); end
      repeat (40) @(negedge clk);
      checks++; if (rd_rdy(0) !== 1'b1 || rd_res(0) !== 16'd101) begin errors++; $display("FAIL busy_no_extra got %0d ready %b want 101 1", rd_res(0), rd_rdy(0)); end
      @(negedge clk); set_in(0, 1, 0, 0); rst = 1'b1;
      @(negedge clk); set_in(0, 0, 0, 0); rst = 1'b0;
      model_reset();
      checks++; if (rd_res(0) !== 16'd1 || rd_rdy(0) !== 1'b1 || rd_err(0) !== 1'b0) begin errors++; $display("FAIL go_with_rst got %0d/%b/%b want 1/1/0", rd_res(0), rd_rdy(0), rd_err(0)); end
   endtask

   task automatic test_reset_mid();
      bit acc, to, ok;
      int c;
      @(negedge clk); set_in(0, 1, 1, 65521);
      @(negedge clk); set_in(0, 0, 0, 0);
      repeat (30) @(negedge clk);
      c = 0;
      while (u16.state_q != primogen_pkg::DIV && c < 100) begin @(negedge clk); c++; end
      checks++; if (c >= 100 || rd_rdy(0) !== 1'b0) begin errors++; $display("FAIL mid_busy ready %b want 0", rd_rdy(0)); end
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      model_reset();
      checks++; if (rd_res(0) !== 16'd1 || rd_rdy(0) !== 1'b1 || rd_err(0) !== 1'b0) begin errors++; $display("FAIL mid_reset got %0d/%b/%b want 1/1/0", rd_res(0), rd_rdy(0), rd_err(0)); end
      model_op(0, 0, 0, acc);
      op(0, 0, 0, acc, to, ok);
      checks++; if (to || !ok || rd_res(0) !== 16'd2) begin errors++; $display("FAIL mid_resume got %0d want 2", rd_res(0)); end
   endtask

   initial begin
      comp[0] = 1; comp[1] = 1;
      for (int i = 2; i * i < 65536; i++)
         if (!comp[i]) for (int j = i * i; j < 65536; j += i) comp[j] = 1;
      test_reset();
      test_sequence();
      test_seeded();
      test_overflow();
      test_busy();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
